// File: rtl/parity_frame_gen.sv
// parity_frame_gen
//
// Streaming row/column parity generator with valid/ready flow control.
// Every accepted data word leaves as {row_parity, word}. A longitudinal
// (column) parity is accumulated over the frame. One trailer word carrying
// that column parity follows the last word of the frame.
//
// Parameters:
//   WIDTH  data word width in bits (>= 2)
//   ODD    parity sense: 0 = even (total ones incl. parity bit even), 1 = odd
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    source presents a word
//   in_ready    block accepts a word this cycle
//   in_data     data word [WIDTH-1:0]
//   in_last     word is the last of its frame
//   out_valid   out_data is valid
//   out_ready   sink accepts a word this cycle
//   out_data    {parity, word} [WIDTH:0], parity in the MSB
//   out_last    word is the frame trailer
//   busy        frame in progress
//   err_inject  (only with PARITY_ERR_INJECT_EN defined) arms a one-shot
//               parity corruption of the next emitted data word
//
// Optional feature macro: PARITY_ERR_INJECT_EN
//
// state   | meaning
// --------+-------------------------------------------------------------
// DATA    | accepting data words; each one loads the output register
// TRAILER | last word taken; waiting for a free output register to
//         | load the column-parity trailer

module parity_frame_gen #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_last,
`ifdef PARITY_ERR_INJECT_EN
  input  logic             err_inject,
`endif
  output logic             busy
);

  localparam logic [0:0] ST_DATA    = 1'b0;
  localparam logic [0:0] ST_TRAILER = 1'b1;

  function automatic logic row_parity(input logic [WIDTH-1:0] w);
    return (^w) ^ ODD;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] lrc_q, lrc_d;
  logic             lrc_active_q, lrc_active_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             inj_flag_q, inj_flag_d;

  logic             out_free;
  logic             accept;
  logic             inj_now;

  // Output register can take a new word when empty or being drained now.
  assign out_free = !out_valid_q || out_ready;

`ifdef PARITY_ERR_INJECT_EN
  // A pulse in the same cycle as a load still corrupts that load.
  assign inj_now = inj_flag_q | err_inject;
`else
  assign inj_now = 1'b0;
`endif

  assign in_ready = (state_q == ST_DATA) && out_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    lrc_d        = lrc_q;
    lrc_active_d = lrc_active_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    inj_flag_d   = inj_now;
    // A transferred word leaves unless something reloads the register below.
    out_valid_d  = out_valid_q && !out_ready;

    case (state_q)
      ST_DATA: begin
        if (accept) begin
          out_valid_d  = 1'b1;
          out_data_d   = {row_parity(in_data) ^ inj_now, in_data};
          out_last_d   = 1'b0;
          inj_flag_d   = 1'b0;
          lrc_d        = lrc_q ^ in_data;
          lrc_active_d = 1'b1;
          if (in_last) begin
            state_d = ST_TRAILER;
          end
        end
      end
      ST_TRAILER: begin
        // lrc_q already folds in the last word, accepted a cycle earlier.
        // The trailer never carries an injected error; the flag stays armed.
        if (out_free) begin
          out_valid_d  = 1'b1;
          out_data_d   = {row_parity(lrc_q), lrc_q};
          out_last_d   = 1'b1;
          lrc_d        = '0;
          lrc_active_d = 1'b0;
          state_d      = ST_DATA;
        end
      end
      default: begin
        state_d = ST_DATA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_DATA;
      lrc_q        <= '0;
      lrc_active_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      inj_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lrc_q        <= lrc_d;
      lrc_active_q <= lrc_active_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      inj_flag_q   <= inj_flag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = lrc_active_q;

endmodule

// File: tb/tb_parity_frame_gen.sv
module tb_parity_frame_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_last, busy;
  logic [8:0] out_data;
  logic       err_inject;

  logic       o_in_valid, o_in_last, o_out_ready;
  logic [7:0] o_in_data;
  logic       o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [8:0] o_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_gen #(.WIDTH(8), .ODD(1'b0)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
`ifdef PARITY_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .busy(busy)
  );

  parity_frame_gen #(.WIDTH(8), .ODD(1'b1)) u_odd (
    .clk(clk), .reset(reset),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data), .in_last(o_in_last),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data), .out_last(o_out_last),
`ifdef PARITY_ERR_INJECT_EN
    .err_inject(1'b0),
`endif
    .busy(o_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    err_inject = 1'b0;
    o_in_valid = 1'b0; o_in_last = 1'b0; o_in_data = 8'h00; o_out_ready = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 9'h000) begin errors++; $display("FAIL reset_out_data got %h exp 000", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 9'h0A5 || out_last !== 1'b0) begin errors++;
      $display("FAIL single_data got v=%b d=%h l=%b exp v=1 d=0a5 l=0", out_valid, out_data, out_last); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 9'h0A5 || out_last !== 1'b1) begin errors++;
      $display("FAIL single_trailer got v=%b d=%h l=%b exp v=1 d=0a5 l=1", out_valid, out_data, out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_three_word();
    logic [7:0] words [3];
    logic [8:0] exp_out [4];
    logic [3:0] exp_last;
    logic [3:0] exp_rdy;
    int         bubbles;
    words = '{8'h01, 8'h03, 8'h07};
    exp_out = '{9'h101, 9'h003, 9'h107, 9'h005};
    exp_last = 4'b1000;
    exp_rdy  = 4'b1011;   // in_ready after each output cycle, bit i = cycle i
    bubbles = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        in_valid = 1'b1; in_data = words[i]; in_last = (i == 2);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      step();
      in_valid = 1'b0; in_last = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_out[i] || out_last !== exp_last[i]) begin errors++;
        $display("FAIL three_out%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, out_valid, out_data, out_last, exp_out[i], exp_last[i]); end
      checks++; if (in_ready !== exp_rdy[i]) begin errors++;
        $display("FAIL three_in_ready%0d got %b exp %b", i, in_ready, exp_rdy[i]); end
      if (in_ready === 1'b0) bubbles++;
    end
    checks++; if (bubbles != 1) begin errors++; $display("FAIL three_bubbles got %0d exp 1", bubbles); end
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL three_idle got v=%b busy=%b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0F; in_last = 1'b0;
    step();
    in_data = 8'h10; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 9'h00F || out_last !== 1'b0) begin errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h l=%b exp v=1 d=00f l=0", i, out_valid, out_data, out_last); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b exp 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 9'h110 || out_last !== 1'b0) begin errors++;
      $display("FAIL bp_next got v=%b d=%h l=%b exp v=1 d=110 l=0", out_valid, out_data, out_last); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 9'h11F || out_last !== 1'b1) begin errors++;
      $display("FAIL bp_trailer got v=%b d=%h l=%b exp v=1 d=11f l=1", out_valid, out_data, out_last); end
    step();
  endtask

  task automatic test_odd();
    o_out_ready = 1'b1;
    o_in_valid = 1'b1; o_in_data = 8'h00; o_in_last = 1'b1;
    step();
    o_in_valid = 1'b0; o_in_last = 1'b0;
    checks++; if (o_out_valid !== 1'b1 || o_out_data !== 9'h100 || o_out_last !== 1'b0) begin errors++;
      $display("FAIL odd_data got v=%b d=%h l=%b exp v=1 d=100 l=0", o_out_valid, o_out_data, o_out_last); end
    step();
    checks++; if (o_out_valid !== 1'b1 || o_out_data !== 9'h100 || o_out_last !== 1'b1) begin errors++;
      $display("FAIL odd_trailer got v=%b d=%h l=%b exp v=1 d=100 l=1", o_out_valid, o_out_data, o_out_last); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 9'h0FF || busy !== 1'b1) begin errors++;
      $display("FAIL mid_first got d=%h busy=%b exp d=0ff busy=1", out_data, busy); end
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 9'h000) begin errors++;
      $display("FAIL mid_reset got v=%b busy=%b d=%h exp 0 0 000", out_valid, busy, out_data); end
    // in_last without in_valid must not start a trailer
    in_last = 1'b1; in_data = 8'h55;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL mid_last_no_valid got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 9'h101 || out_last !== 1'b0) begin errors++;
      $display("FAIL mid_data got v=%b d=%h l=%b exp v=1 d=101 l=0", out_valid, out_data, out_last); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 9'h101 || out_last !== 1'b1) begin errors++;
      $display("FAIL mid_trailer got v=%b d=%h l=%b exp v=1 d=101 l=1", out_valid, out_data, out_last); end
    step();
  endtask

`ifdef PARITY_ERR_INJECT_EN
  task automatic test_err_inject();
    out_ready = 1'b1;
    err_inject = 1'b1;
    step();
    err_inject = 1'b0;
    step();
    in_valid = 1'b1; in_data = 8'h03; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 9'h103 || out_last !== 1'b0) begin errors++;
      $display("FAIL inj_data got v=%b d=%h l=%b exp v=1 d=103 l=0", out_valid, out_data, out_last); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 9'h003 || out_last !== 1'b1) begin errors++;
      $display("FAIL inj_trailer got v=%b d=%h l=%b exp v=1 d=003 l=1", out_valid, out_data, out_last); end
    in_valid = 1'b1; in_data = 8'h03; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_data !== 9'h003) begin errors++;
      $display("FAIL inj_oneshot got d=%h exp 003", out_data); end
    step();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_three_word();
    test_backpressure();
    test_odd();
    test_reset_mid_frame();
`ifdef PARITY_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
